// File: rtl/time_setter_if.sv
// rtl/time_setter_if.sv - button inputs and display/commit outputs of time_setter
//
// Purpose: bundles the raw buttons and all outputs of time_setter.
//   master : drives buttons, observes outputs (board / testbench side)
//   slave  : time_setter side
// Signals:
//   btn_inc, btn_next, btn_load      raw asynchronous buttons
//   units_seconds .. tens_minutes    BCD digits being edited (4 bits each)
//   cursor                           active digit 0..3
//   editing                          high while in EDIT
//   seconds, minutes                 last committed binary time (6 bits each)
//   load                             one-cycle commit strobe

interface time_setter_if;
  logic       btn_inc;
  logic       btn_next;
  logic       btn_load;
  logic [3:0] units_seconds;
  logic [3:0] tens_seconds;
  logic [3:0] units_minutes;
  logic [3:0] tens_minutes;
  logic [1:0] cursor;
  logic       editing;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic       load;

  modport master (
    output btn_inc, btn_next, btn_load,
    input  units_seconds, tens_seconds, units_minutes, tens_minutes,
    input  cursor, editing, seconds, minutes, load
  );

  modport slave (
    input  btn_inc, btn_next, btn_load,
    output units_seconds, tens_seconds, units_minutes, tens_minutes,
    output cursor, editing, seconds, minutes, load
  );
endinterface

// File: rtl/time_setter.sv
// rtl/time_setter.sv - debounced three-button mm:ss entry with BCD-to-binary commit
//
// Purpose: three raw buttons edit four BCD digits under a cursor; a load press
// converts the digits to binary seconds/minutes and strobes load for one cycle.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   ts     time_setter_if.slave: raw buttons in; digits, cursor, editing,
//          seconds, minutes, load out
// Parameter:
//   DEBOUNCE_CYCLES  consecutive stable synchronized samples to accept a level (2..65535)

module time_setter #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  time_setter_if.slave ts
);

  localparam int BTN_INC  = 0;
  localparam int BTN_NEXT = 1;
  localparam int BTN_LOAD = 2;

  // Counter reaches CNT_MAX on the DEBOUNCE_CYCLES-th consecutive differing sample.
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_EDIT    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_LOAD    = 2'd2
  } state_t;

  logic [2:0] raw;
  logic [2:0] evt;

  assign raw = {ts.btn_load, ts.btn_next, ts.btn_inc};

  // Per-button synchronizer + debouncer + rising-edge event.
  // The event is registered on the same edge that accepts the new high level,
  // so the FSM reacts DEBOUNCE_CYCLES+3 edges after the raw input is first sampled.
  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic        sync1;
    logic        sync2;
    logic        level;
    logic        ev;
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        level <= 1'b0;
        ev    <= 1'b0;
        cnt   <= '0;
      end else begin
        sync1 <= raw[g];
        sync2 <= sync1;
        ev    <= 1'b0;
        if (sync2 != level) begin
          if (cnt == CNT_MAX) begin
            level <= sync2;
            cnt   <= '0;
            ev    <= sync2;   // only a 0->1 acceptance is an event
          end else begin
            cnt <= cnt + 16'd1;
          end
        end else begin
          // any sample matching the current level breaks the run
          cnt <= '0;
        end
      end
    end

    assign evt[g] = ev;
  end

  // Wrap to zero at the limit; values above the limit also wrap to zero.
  function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  // tens*10 + units as tens*8 + tens*2 + units; maximum 59 fits in 6 bits.
  function automatic logic [5:0] to_bin(input logic [3:0] tens, input logic [3:0] units);
    logic [5:0] t;
    t = {2'b00, tens};
    return (t << 3) + (t << 1) + {2'b00, units};
  endfunction

  state_t     state;
  logic [3:0] us_q, ts_q, um_q, tm_q;
  logic [1:0] cursor_q;
  logic       editing_q;
  logic [5:0] sec_q, min_q;
  logic       load_q;
  logic [5:0] sec_calc, min_calc;

  // Digits are frozen outside EDIT, so the conversion seen in CONVERT is stable.
  always_comb begin
    sec_calc = to_bin(ts_q, us_q);
    min_calc = to_bin(tm_q, um_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_EDIT;
      us_q      <= 4'd0;
      ts_q      <= 4'd0;
      um_q      <= 4'd0;
      tm_q      <= 4'd0;
      cursor_q  <= 2'd0;
      editing_q <= 1'b1;
      sec_q     <= 6'd0;
      min_q     <= 6'd0;
      load_q    <= 1'b0;
    end else begin
      case (state)
        ST_EDIT: begin
          // load > next > inc; lower-priority events in the same cycle are dropped
          if (evt[BTN_LOAD]) begin
            state     <= ST_CONVERT;
            editing_q <= 1'b0;
          end else if (evt[BTN_NEXT]) begin
            cursor_q <= cursor_q + 2'd1;
          end else if (evt[BTN_INC]) begin
            case (cursor_q)
              2'd0:    us_q <= bump(us_q, 4'd9);
              2'd1:    ts_q <= bump(ts_q, 4'd5);
              2'd2:    um_q <= bump(um_q, 4'd9);
              default: tm_q <= bump(tm_q, 4'd5);
            endcase
          end
        end
        ST_CONVERT: begin
          // results land together with load so they are new in the LOAD cycle
          state  <= ST_LOAD;
          sec_q  <= sec_calc;
          min_q  <= min_calc;
          load_q <= 1'b1;
        end
        ST_LOAD: begin
          state     <= ST_EDIT;
          load_q    <= 1'b0;
          editing_q <= 1'b1;
        end
        default: begin
          state     <= ST_EDIT;
          load_q    <= 1'b0;
          editing_q <= 1'b1;
        end
      endcase
    end
  end

  assign ts.units_seconds = us_q;
  assign ts.tens_seconds  = ts_q;
  assign ts.units_minutes = um_q;
  assign ts.tens_minutes  = tm_q;
  assign ts.cursor        = cursor_q;
  assign ts.editing       = editing_q;
  assign ts.seconds       = sec_q;
  assign ts.minutes       = min_q;
  assign ts.load          = load_q;

endmodule

// File: tb/tb_time_setter.sv
// tb/tb_time_setter.sv - scoreboard bench for time_setter with DEBOUNCE_CYCLES=4

module tb_time_setter;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  time_setter_if tsi ();

  time_setter #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (rst_n),
    .ts    (tsi)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [17:0] val;
  } disp_exp_t;

  typedef struct {
    string       tag;
    logic [11:0] val;   // {seconds, minutes}
  } load_exp_t;

  disp_exp_t disp_q[$];
  load_exp_t load_q[$];

  // reference model of digits/cursor
  int md[4];
  int mcur;

  function automatic logic [17:0] model_vec();
    return {4'(md[3]), 4'(md[2]), 4'(md[1]), 4'(md[0]), 2'(mcur)};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {tsi.tens_minutes, tsi.units_minutes, tsi.tens_seconds, tsi.units_seconds, tsi.cursor};
  endfunction

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: tsi.btn_inc = v;
      1: tsi.btn_next = v;
      default: tsi.btn_load = v;
    endcase
  endtask

  task automatic push_disp(input string tag);
    disp_exp_t e;
    e.tag = tag;
    e.val = model_vec();
    disp_q.push_back(e);
  endtask

  task automatic push_load(input string tag);
    load_exp_t e;
    e.tag = tag;
    e.val = {6'(md[1] * 10 + md[0]), 6'(md[3] * 10 + md[2])};
    load_q.push_back(e);
  endtask

  // b: 0=inc 1=next 2=load; model updated and expectation queued before driving
  task automatic press(input int b, input string tag);
    if (b == 0) begin
      md[mcur] = (md[mcur] + 1) % (((mcur % 2) == 0) ? 10 : 6);
      push_disp(tag);
    end else if (b == 1) begin
      mcur = (mcur + 1) % 4;
      push_disp(tag);
    end else begin
      push_load(tag);
    end
    @(negedge clk);
    set_btn(b, 1'b1);
    repeat (8) @(negedge clk);
    set_btn(b, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  // monitor
  bit          mon_en = 0;
  logic [17:0] prev_disp;
  logic [11:0] prev_sm;
  int          edit_low_run = 0;
  int          load_run = 0;

  always @(negedge clk) begin
    logic [17:0] cur;
    logic [11:0] sm;
    disp_exp_t   de;
    load_exp_t   le;
    if (mon_en) begin
      cur = dut_vec();
      sm  = {tsi.seconds, tsi.minutes};
      if (cur !== prev_disp) begin
        if (disp_q.size() > 0) begin
          de = disp_q.pop_front();
          check(de.tag, 32'(cur), 32'(de.val));
        end else begin
          check("disp_unexpected", 32'(cur), 32'(prev_disp));
        end
        prev_disp = cur;
      end
      if (!rst_n) begin
        prev_sm      = sm;
        edit_low_run = 0;
        load_run     = 0;
      end else begin
        if (tsi.load === 1'b1) begin
          load_run++;
          if (load_q.size() > 0) begin
            le = load_q.pop_front();
            check(le.tag, 32'(sm), 32'(le.val));
          end else begin
            check("load_unexpected", 32'(tsi.load), 32'd0);
          end
          prev_sm = sm;
        end else begin
          if (load_run > 0) begin
            check("load_len", load_run, 1);
            load_run = 0;
          end
          if (sm !== prev_sm) begin
            check("sm_hold", 32'(sm), 32'(prev_sm));
            prev_sm = sm;
          end
        end
        if (tsi.editing === 1'b0) begin
          edit_low_run++;
        end else if (edit_low_run > 0) begin
          check("edit_low_len", edit_low_run, 2);
          edit_low_run = 0;
        end
      end
    end
  end

  initial begin
    tsi.btn_inc  = 1'b0;
    tsi.btn_next = 1'b0;
    tsi.btn_load = 1'b0;
    for (int i = 0; i < 4; i++) md[i] = 0;
    mcur = 0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_disp", 32'(dut_vec()), 32'd0);
    check("rst_sec", 32'(tsi.seconds), 32'd0);
    check("rst_min", 32'(tsi.minutes), 32'd0);
    check("rst_load", 32'(tsi.load), 32'd0);
    check("rst_editing", 32'(tsi.editing), 32'd1);
    prev_disp = dut_vec();
    prev_sm   = {tsi.seconds, tsi.minutes};
    mon_en    = 1;
    rst_n     = 1'b1;
    repeat (2) @(negedge clk);

    // latency: first sampling edge counts as edge 1, digit changes on edge DEB+3
    md[0] = 1;
    push_disp("lat_inc");
    tsi.btn_inc = 1'b1;
    repeat (DEB + 2) @(posedge clk);
    #1 check("lat_early", 32'(tsi.units_seconds), 32'd0);
    @(posedge clk);
    #1 check("lat_edge", 32'(tsi.units_seconds), 32'd1);
    repeat (20 - DEB - 3) @(negedge clk);
    tsi.btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    check("lat_single", 32'(dut_vec()), 32'(model_vec()));

    // bounce: toggling every 2 cycles never survives the debouncer
    for (int i = 0; i < 20; i++) begin
      tsi.btn_inc = ~tsi.btn_inc;
      repeat (2) @(negedge clk);
    end
    tsi.btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    check("bounce_hold", 32'(dut_vec()), 32'(model_vec()));

    // enter 23:59 and commit
    while (md[0] != 9) press(0, "us_inc");
    press(1, "next");
    while (md[1] != 5) press(0, "ts_inc");
    press(1, "next");
    while (md[2] != 3) press(0, "um_inc");
    press(1, "next");
    while (md[3] != 2) press(0, "tm_inc");
    press(1, "next");
    press(2, "load_59_23");
    check("load_digits_kept", 32'(dut_vec()), 32'(model_vec()));

    // wraps
    for (int i = 0; i < 10; i++) press(0, "us_wrap");
    press(1, "next");
    for (int i = 0; i < 6; i++) press(0, "ts_wrap");
    for (int i = 0; i < 4; i++) press(1, "cursor_wrap");
    check("cursor_back", 32'(tsi.cursor), 32'(mcur));
    press(0, "ts_after_wrap");   // tens_seconds 5 -> 0

    // load and inc rising together: load wins, inc dropped
    push_load("load_simul");
    @(negedge clk);
    tsi.btn_load = 1'b1;
    tsi.btn_inc  = 1'b1;
    repeat (8) @(negedge clk);
    tsi.btn_load = 1'b0;
    tsi.btn_inc  = 1'b0;
    repeat (8) @(negedge clk);
    check("simul_digits", 32'(dut_vec()), 32'(model_vec()));

    // inc events landing in CONVERT (offset 1) and LOAD (offset 2) are dropped
    for (int off = 1; off <= 2; off++) begin
      push_load("load_busy");
      @(negedge clk);
      tsi.btn_load = 1'b1;
      repeat (off) @(negedge clk);
      tsi.btn_inc = 1'b1;
      repeat (8) @(negedge clk);
      tsi.btn_load = 1'b0;
      tsi.btn_inc  = 1'b0;
      repeat (8) @(negedge clk);
      check("busy_digits", 32'(dut_vec()), 32'(model_vec()));
    end

    // reset while in CONVERT aborts the commit
    @(negedge clk);
    tsi.btn_load = 1'b1;
    repeat (DEB + 3) @(posedge clk);
    #1 check("in_convert", 32'(tsi.editing), 32'd0);
    for (int i = 0; i < 4; i++) md[i] = 0;
    mcur = 0;
    if (dut_vec() !== model_vec()) push_disp("rst_abort_disp");
    rst_n = 1'b0;
    tsi.btn_load = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_sec", 32'(tsi.seconds), 32'd0);
    check("abort_min", 32'(tsi.minutes), 32'd0);
    check("abort_editing", 32'(tsi.editing), 32'd1);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_load", 32'(tsi.load), 32'd0);
    check("abort_disp", 32'(dut_vec()), 32'd0);
    check("abort_sec_after", 32'(tsi.seconds), 32'd0);

    // editing works again after the aborted commit
    press(0, "post_rst_inc");
    press(2, "post_rst_load");

    repeat (5) @(negedge clk);
    check("disp_q_drained", disp_q.size(), 0);
    check("load_q_drained", load_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/time_setter.md
TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples before a button level is accepted; legal range 2..65535.
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; asserting it forces every register to its reset value immediately, and release is sampled on clk.
REQ-004 Port: btn_inc  input  1  raw, asynchronous button that increments the digit under the cursor.
REQ-005 Port: btn_next  input  1  raw, asynchronous button that advances the cursor.
REQ-006 Port: btn_load  input  1  raw, asynchronous button that commits the entered time.
REQ-007 Port: units_seconds, tens_seconds, units_minutes, tens_minutes  output  4 each  BCD digits being edited, for the display illuminator.
REQ-008 Port: cursor  output  2  active digit: 0=units_seconds, 1=tens_seconds, 2=units_minutes, 3=tens_minutes.
REQ-009 Port: editing  output  1  high only in state EDIT.
REQ-010 Port: seconds, minutes  output  6 each  binary value of the last committed entry, held between loads.
REQ-011 Port: load  output  1  one-cycle strobe; seconds/minutes are valid and new in that cycle.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its debounced level only after DEBOUNCE_CYCLES consecutive identical synchronized samples; any differing sample restarts the count.
REQ-013 A button event SHALL be a registered 0->1 transition of the debounced level, lasting one cycle; release and bounce generate no event.
REQ-014 Event latency SHALL be exactly DEBOUNCE_CYCLES+3 clk edges from the first edge sampling the raw input high (input held stable) to the edge at which the digit or cursor changes or the state leaves EDIT.
REQ-015 FSM states SHALL be EDIT, CONVERT and LOAD; reset enters EDIT.
REQ-016 In EDIT, an inc event SHALL increment the cursor digit modulo its limit: units digits 9->0, tens digits 5->0; other digits are unchanged.
REQ-017 In EDIT, a next event SHALL advance the cursor 0->1->2->3->0.
REQ-018 In EDIT, a load event SHALL transition to CONVERT; digits and cursor are unchanged.
REQ-019 Simultaneous events in one cycle SHALL be resolved load > next > inc, and lower-priority events in that cycle are discarded.
REQ-020 CONVERT SHALL last exactly one cycle and compute seconds = tens_seconds*10 + units_seconds and minutes = tens_minutes*10 + units_minutes into 6-bit results (maximum 59, no overflow), using shift-add (x*8 + x*2), then go to LOAD.
REQ-021 LOAD SHALL last exactly one cycle, assert load=1, present the new seconds/minutes, then return to EDIT.
REQ-022 Button events occurring in CONVERT or LOAD SHALL be discarded, not queued; debouncers keep running.
REQ-023 Digits SHALL persist after a load so the user can re-edit from the committed value; cursor is not reset by a load.
REQ-024 seconds/minutes SHALL change only in the LOAD cycle.

Reset
REQ-025 On reset assertion, all digits, cursor, seconds and minutes SHALL become 0, load=0, editing=1 (state EDIT).
REQ-026 Synchronizers, debouncer counters and debounced levels SHALL reset to 0, so a button held through reset release yields exactly one event after DEBOUNCE_CYCLES+3 edges.
REQ-027 Reset asserted in CONVERT or LOAD SHALL abort without any load pulse and leave seconds/minutes at 0.

Verification (DEBOUNCE_CYCLES=4)
REQ-028 Press inc for 20 cycles after reset -> units_seconds becomes 1 exactly 7 edges after the press, single increment, load stays 0.
REQ-029 Raw btn_inc toggling every 2 cycles for 40 cycles -> no digit change.
REQ-030 Enter digits 5,9 (seconds tens/units) and 2,3 (minutes), then press load -> load high one cycle, seconds=59, minutes=23, editing low for exactly 2 cycles.
REQ-031 Ten inc presses on units_seconds -> digit wraps 9->0; six presses on tens_seconds -> 5->0; four next presses -> cursor returns to 0.
REQ-032 btn_load and btn_inc rising on the same cycle -> only load occurs, digit unchanged; inc pressed during CONVERT/LOAD -> ignored.
REQ-033 Assert reset during CONVERT -> no load pulse, all outputs at reset values, editing=1.
